mult_seq_radix: RTL

MULT_SEQ_RADIX -- requirements
Module: mult_seq_radix

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_digit_pp.sv | 22 ++
 rtl/mult_seq_radix.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and configuration checks for the sequential radix-2^DIGIT multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit d set means DIGIT = d is supported (1, 2 or 4 bits per cycle).
    localparam logic [4:0] DIGIT_LEGAL_MASK = 5'b10110;

    function automatic bit cfg_legal(int unsigned width, int unsigned digit);
        if (digit == 0 || digit > 4) begin
            return 1'b0;
        end
        return DIGIT_LEGAL_MASK[digit[2:0]] && (width >= 8) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Combinational partial product: one DIGIT-bit multiplier digit times the 2*WIDTH multiplicand.
module mult_digit_pp
    import mult_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 2
) (
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [DIGIT-1:0]   digit_i,
    output logic [2*WIDTH-1:0] pp_o
);

    always_comb begin
        pp_o = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (digit_i[i]) begin
                pp_o = pp_o + (mcand_i << i);
            end
        end
    end

endmodule

// File: rtl/mult_seq_radix.sv
// Sequential sign-magnitude multiplier retiring DIGIT multiplier bits per cycle,
// with early termination once the remaining multiplier bits are all zero.
module mult_seq_radix
    import mult_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;

    if (!cfg_legal(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("mult_seq_radix: illegal WIDTH=%0d / DIGIT=%0d combination", WIDTH, DIGIT);
    end

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;

    logic [WIDTH-1:0] op1_mag, op2_mag, mplier_shift;
    logic [PW-1:0]    pp, acc_next;
    logic             sign;

    // Most-negative operand negates to itself, which reads correctly as 2^(WIDTH-1) unsigned.
    assign op1_mag = (signed_mode && op1[WIDTH-1]) ? -op1 : op1;
    assign op2_mag = (signed_mode && op2[WIDTH-1]) ? -op2 : op2;

    assign sign         = mode_q & neg_q;
    assign mplier_shift = mplier_q >> DIGIT;
    assign acc_next     = acc_q + pp;

    mult_digit_pp #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) u_pp (
        .mcand_i(mcand_q),
        .digit_i(mplier_q[DIGIT-1:0]),
        .pp_o   (pp)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d   = signed_mode;
                    neg_d    = op1[WIDTH-1] ^ op2[WIDTH-1];
                    mcand_d  = {{WIDTH{1'b0}}, op1_mag};
                    mplier_d = op2_mag;
                    acc_d    = '0;
                    if (op2_mag == '0) begin
                        product_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << DIGIT;
                mplier_d = mplier_shift;
                if (mplier_shift == '0) begin
                    product_d = sign ? -acc_next : acc_next;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CALC);
    assign out_valid = (state_q == ST_DONE);
    assign product   = product_q;

endmodule
